dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-port `data_memory`. It shares the memory between the core load/store path (port 0) and the program-loader/DMA port (port 1). The arbiter uses round-robin grants, supports a bounded burst lock for port 1, and rejects misaligned or illegal accesses before they reach memory. All responses are registered, giving a fixed 1-cycle response latency per grant.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_access_check.sv | 33 +++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: RISC-V width codes, FSM states, port ids.
package dmem_arb_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    RR   = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality/alignment check for one memory access.
// Zero latency; a fault means the access must not reach memory.
module dmem_access_check
  import dmem_arb_pkg::*;
(
  input  logic       we_i,
  input  logic [2:0] func3_i,
  input  logic [1:0] addr_lo_i,
  output logic       fault_o
);

  logic illegal;
  logic misaligned;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (func3_i)
      F3_B:  illegal = 1'b0;
      F3_H:  misaligned = addr_lo_i[0];
      F3_W:  misaligned = |addr_lo_i;
      // Unsigned widths only exist for loads.
      F3_BU: illegal = we_i;
      F3_HU: begin
        illegal    = we_i;
        misaligned = addr_lo_i[0];
      end
      default: illegal = 1'b1;
    endcase
    fault_o = illegal | misaligned;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded port-1 burst lock in front of a single-port data memory.
// Grant is combinational; responses are registered and pulse one cycle after the grant. Requesters hold until granted.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic        r0_we,
  input  logic [2:0]  r0_func3,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic        r1_we,
  input  logic [2:0]  r1_func3,
  input  logic        r1_lock,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  output logic [2:0]  mem_func3,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned CW = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  arb_state_e    state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  logic          gnt_vld;
  logic          sel;
  logic          win_we;
  logic [31:0]   win_addr;
  logic          fault;

  logic          rsp_vld_q;
  logic          rsp_port_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_dat_q;

  always_comb begin
    gnt_vld = 1'b0;
    sel     = PORT0;
    if (!rst) begin
      if (state_q == LOCK && r1_req) begin
        gnt_vld = 1'b1;
        sel     = PORT1;
      end else if (r0_req && r1_req) begin
        gnt_vld = 1'b1;
        sel     = ~last_gnt_q;
      end else if (r0_req) begin
        gnt_vld = 1'b1;
        sel     = PORT0;
      end else if (r1_req) begin
        gnt_vld = 1'b1;
        sel     = PORT1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    if (gnt_vld) begin
      last_gnt_d = sel;
    end
    case (state_q)
      RR: begin
        if (gnt_vld && sel == PORT1 && r1_lock && (MAX_LOCK > 1)) begin
          state_d    = LOCK;
          lock_cnt_d = CNT_ONE;
        end
      end
      LOCK: begin
        if (!r1_req) begin
          state_d = RR;
        end else begin
          // Port 1 is always granted here; count saturates rather than wraps.
          lock_cnt_d = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_ONE;
          if (!r1_lock || lock_cnt_d == CNT_MAX) begin
            state_d = RR;
          end
        end
      end
      default: state_d = RR;
    endcase
  end

  assign win_addr       = sel ? r1_addr : r0_addr;
  assign win_we         = sel ? r1_we : r0_we;
  assign mem_address    = win_addr;
  assign mem_write_data = sel ? r1_wdata : r0_wdata;
  assign mem_func3      = sel ? r1_func3 : r0_func3;

  dmem_access_check u_check (
    .we_i      (win_we),
    .func3_i   (mem_func3),
    .addr_lo_i (win_addr[1:0]),
    .fault_o   (fault)
  );

  assign mem_write = gnt_vld & win_we & ~fault;
  assign mem_read  = gnt_vld & ~win_we & ~fault;
  assign r0_gnt    = gnt_vld & (sel == PORT0);
  assign r1_gnt    = gnt_vld & (sel == PORT1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RR;
      last_gnt_q <= PORT1;
      lock_cnt_q <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_port_q <= PORT0;
      rsp_err_q  <= 1'b0;
      rsp_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rsp_vld_q  <= gnt_vld;
      rsp_port_q <= sel;
      rsp_err_q  <= gnt_vld & fault;
      rsp_dat_q  <= mem_read ? mem_read_data : '0;
    end
  end

  assign r0_rvalid = rsp_vld_q & (rsp_port_q == PORT0);
  assign r1_rvalid = rsp_vld_q & (rsp_port_q == PORT1);
  assign r0_rdata  = r0_rvalid ? rsp_dat_q : '0;
  assign r1_rdata  = r1_rvalid ? rsp_dat_q : '0;
  assign r0_err    = r0_rvalid & rsp_err_q;
  assign r1_err    = r1_rvalid & rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory model, cycle monitor with a reference arbiter, directed and random traffic.
module tb_dmem_arbiter;

  localparam int MAXL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r0_gnt, r0_rvalid, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic [2:0]  r0_func3;
  logic        r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic [2:0]  r1_func3;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write, mem_read;
  logic [2:0]  mem_func3;

  int total = 0;
  int bad = 0;
  logic [7:0] dmem [0:255];
  logic [7:0] gold [0:255];
  int glog [$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_we(r0_we), .r0_func3(r0_func3),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_we(r1_we), .r1_func3(r1_func3),
    .r1_lock(r1_lock),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_read(mem_read), .mem_func3(mem_func3), .mem_read_data(mem_read_data)
  );

  function automatic void check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd2:    return w;
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  // Width code rules written from the access-size point of view.
  function automatic bit exp_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || (f3[1:0] == 2'b01 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] pack_log();
    logic [31:0] v;
    v = '0;
    foreach (glog[i]) v = {v[30:0], glog[i][0]};
    return v;
  endfunction

  always_comb begin
    mem_read_data = fmt_load({dmem[mem_address[7:0] + 8'd3], dmem[mem_address[7:0] + 8'd2],
                              dmem[mem_address[7:0] + 8'd1], dmem[mem_address[7:0]]}, mem_func3);
  end

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_write === 1'b1) begin
        dmem[mem_address[7:0]] = mem_write_data[7:0];
        if (mem_func3 != 3'd0) dmem[mem_address[7:0] + 8'd1] = mem_write_data[15:8];
        if (mem_func3 == 3'd2) begin
          dmem[mem_address[7:0] + 8'd2] = mem_write_data[23:16];
          dmem[mem_address[7:0] + 8'd3] = mem_write_data[31:24];
        end
      end
    end
  end

  // Reference: p1_owns/streak track a port-1 burst, last is the most recent winner.
  initial begin
    int w, pend_p, streak, last;
    bit s_rst, s_r1, s_lock, p1_owns, pend_v, pend_err, f, e0, e1;
    logic [31:0] pend_dat, wa, wwd, n_dat;
    logic [2:0] wf3;
    logic wwe;
    logic [7:0] ga;
    w = -1; pend_p = 0; streak = 0; last = 1; p1_owns = 0; pend_v = 0; pend_err = 0;
    pend_dat = '0; f = 0; n_dat = '0; wa = '0; wwd = '0; wf3 = '0; wwe = 1'b0;
    for (int i = 0; i < 256; i++) gold[i] = 8'h00;
    forever begin
      @(negedge clk);
      e0 = pend_v && pend_p == 0;
      e1 = pend_v && pend_p == 1;
      check("rsp", 72'({r0_rvalid, r0_err, r0_rdata, r1_rvalid, r1_err, r1_rdata}),
            72'({e0, e0 && pend_err, e0 ? pend_dat : 32'd0, e1, e1 && pend_err, e1 ? pend_dat : 32'd0}));
      s_rst = rst; s_r1 = r1_req; s_lock = r1_lock;
      w = -1;
      if (!s_rst) begin
        if (p1_owns && r1_req) w = 1;
        else if (r0_req && r1_req) w = (last == 1) ? 0 : 1;
        else if (r0_req) w = 0;
        else if (r1_req) w = 1;
      end
      check("gnt", 72'({r0_gnt, r1_gnt}), 72'({w == 0, w == 1}));
      if (w >= 0) begin
        wa  = (w == 1) ? r1_addr : r0_addr;
        wwd = (w == 1) ? r1_wdata : r0_wdata;
        wf3 = (w == 1) ? r1_func3 : r0_func3;
        wwe = (w == 1) ? r1_we : r0_we;
        f   = exp_fault(wwe, wf3, wa);
        ga  = wa[7:0];
        check("memif", 72'({mem_address, mem_write_data, mem_func3, mem_write, mem_read}),
              72'({wa, wwd, wf3, wwe && !f, !wwe && !f}));
        n_dat = (!wwe && !f) ? fmt_load({gold[ga + 8'd3], gold[ga + 8'd2], gold[ga + 8'd1], gold[ga]}, wf3)
                             : 32'd0;
      end else begin
        check("idle", 72'({mem_write, mem_read}), 72'd0);
      end
      @(posedge clk);
      if (s_rst) begin
        p1_owns = 0; streak = 0; last = 1; pend_v = 0;
      end else begin
        pend_v = (w >= 0); pend_p = w; pend_err = f; pend_dat = n_dat;
        if (w >= 0) begin
          glog.push_back(w);
          if (wwe && !f) begin
            gold[ga] = wwd[7:0];
            if (wf3 != 3'd0) gold[ga + 8'd1] = wwd[15:8];
            if (wf3 == 3'd2) begin
              gold[ga + 8'd2] = wwd[23:16];
              gold[ga + 8'd3] = wwd[31:24];
            end
          end
        end
        if (w == 1) begin
          if (p1_owns) begin
            streak++;
            if (!s_lock || streak >= MAXL) p1_owns = 0;
          end else if (s_lock && MAXL > 1) begin
            p1_owns = 1;
            streak = 1;
          end
          last = 1;
        end else if (w == 0) begin
          last = 0;
          p1_owns = 0;
        end else if (p1_owns && !s_r1) begin
          p1_owns = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the granting edge.
  task automatic issue(input bit p, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic lk);
    int n;
    logic g;
    if (p) begin
      r1_we = we; r1_func3 = f3; r1_addr = a; r1_wdata = d; r1_lock = lk; r1_req = 1'b1;
    end else begin
      r0_we = we; r0_func3 = f3; r0_addr = a; r0_wdata = d; r0_req = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      g = p ? r1_gnt : r0_gnt;
    end while (g !== 1'b1 && n < 200);
    check(p ? "p1_gnt_wait" : "p0_gnt_wait", 72'(g), 72'd1);
    @(posedge clk);
    #1;
    if (p) begin
      r1_req = 1'b0; r1_lock = 1'b0;
    end else begin
      r0_req = 1'b0;
    end
  endtask

  initial begin
    int k;
    tbl[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 3'd1, 32'h11, 32'h0,        1'b1, 32'h0};
    tbl[3]  = '{1'b1, 3'd3, 32'h10, 32'h11223344, 1'b1, 32'h0};
    tbl[4]  = '{1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 3'd2, 32'h12, 32'h0,        1'b1, 32'h0};
    tbl[6]  = '{1'b1, 3'd1, 32'h13, 32'h55AA,     1'b1, 32'h0};
    tbl[7]  = '{1'b0, 3'd5, 32'h12, 32'h0,        1'b0, 32'h0000DEAD};
    tbl[8]  = '{1'b0, 3'd0, 32'h13, 32'h0,        1'b0, 32'hFFFFFFDE};
    tbl[9]  = '{1'b0, 3'd1, 32'h10, 32'h0,        1'b0, 32'hFFFFBEEF};
    tbl[10] = '{1'b1, 3'd0, 32'h20, 32'h123456AB, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 3'd4, 32'h20, 32'h0,        1'b0, 32'h000000AB};
    tbl[12] = '{1'b0, 3'd6, 32'h20, 32'h0,        1'b1, 32'h0};
    tbl[13] = '{1'b1, 3'd4, 32'h20, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[14] = '{1'b1, 3'd1, 32'h22, 32'h0000CAFE, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 3'd2, 32'h20, 32'h0,        1'b0, 32'hCAFE00AB};

    // Both ports request LW from inside reset onwards.
    rst = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_func3 = 3'd2; r0_addr = 32'h0; r0_wdata = 32'h0;
    r1_req = 1'b1; r1_we = 1'b0; r1_func3 = 3'd2; r1_addr = 32'h4; r1_wdata = 32'h0; r1_lock = 1'b0;
    @(posedge clk); #1;
    check("rst_quiet", 72'({r0_gnt, r1_gnt, mem_write, mem_read, r0_rvalid, r1_rvalid, r0_err, r1_err}), 72'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    glog.delete();
    fork
      begin for (int i = 0; i < 4; i++) issue(1'b0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0); end
      begin for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 3'd2, 32'h4, 32'h0, 1'b0); end
    join
    check("alt_len", 72'(glog.size()), 72'd8);
    check("alt_seq", 72'(pack_log()), 72'(8'b01010101));

    for (int i = 0; i < 16; i++) begin
      issue(1'b0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 1'b0);
      check($sformatf("tbl%0d", i), 72'({r0_rvalid, r0_err, r0_rdata, r1_rvalid}),
            72'({1'b1, tbl[i].err, tbl[i].rdata, 1'b0}));
    end

    // Burst lock: 12 locked port-1 requests against a waiting port 0.
    repeat (2) @(posedge clk);
    #1;
    glog.delete();
    fork
      begin for (int i = 0; i < 12; i++) issue(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1); end
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) issue(1'b0, 1'b0, 3'd0, 32'h20, 32'h0, 1'b0);
      end
    join
    check("lock_len", 72'(glog.size()), 72'd15);
    check("lock_seq", 72'(pack_log()), 72'(15'b111111110111100));

    // Reset in the third cycle of a port-1 lock.
    repeat (2) @(posedge clk);
    #1;
    r1_we = 1'b0; r1_func3 = 3'd2; r1_addr = 32'h10; r1_lock = 1'b1; r1_req = 1'b1;
    @(negedge clk);
    check("lk_g1", 72'({r0_gnt, r1_gnt}), 72'(2'b01));
    @(posedge clk); #1;
    r0_we = 1'b0; r0_func3 = 3'd2; r0_addr = 32'h10; r0_req = 1'b1;
    @(negedge clk);
    check("lk_g2", 72'({r0_gnt, r1_gnt}), 72'(2'b01));
    @(posedge clk); #1;
    rst = 1'b1;
    check("lk_rsp", 72'({r1_rvalid, r1_rdata}), 72'({1'b1, 32'hDEADBEEF}));
    @(posedge clk); #1;
    rst = 1'b0;
    check("lk_rst_out", 72'({r0_rvalid, r0_err, r0_rdata, r1_rvalid, r1_err, r1_rdata}), 72'd0);
    @(negedge clk);
    check("lk_rst_rr", 72'({r0_gnt, r1_gnt}), 72'(2'b10));
    @(posedge clk); #1;
    r0_req = 1'b0;
    @(negedge clk);
    check("lk_resume", 72'({r0_gnt, r1_gnt}), 72'(2'b01));
    @(posedge clk); #1;
    r1_req = 1'b0; r1_lock = 1'b0;

    // Random traffic on both ports, checked cycle by cycle by the reference.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          issue(1'b0, 1'($urandom_range(1)), 3'($urandom_range(7)), 32'($urandom_range(63)), $urandom, 1'b0);
          k = $urandom_range(2);
          if (k > 0) begin repeat (k) @(posedge clk); #1; end
        end
      end
      begin
        for (int j = 0; j < 150; j++) begin
          issue(1'b1, 1'($urandom_range(1)), 3'($urandom_range(7)), 32'($urandom_range(63)), $urandom,
                1'($urandom_range(3) != 0));
          if ($urandom_range(2) == 0) begin @(posedge clk); #1; end
        end
      end
    join

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
